// File: rtl/pcgen_pkg.sv
// rtl/pcgen_pkg.sv - shared types and helpers for the fetch PC generator
package pcgen_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  // Branch kinds the execute stage resolves into upd_taken
  typedef enum logic [3:0] {
    JMP_NONE = 4'd0,
    JMP_BEQ  = 4'd1,
    JMP_BNE  = 4'd2,
    JMP_BLT  = 4'd3,
    JMP_BGE  = 4'd4,
    JMP_BLTU = 4'd5,
    JMP_BGEU = 4'd6,
    JMP_JAL  = 4'd7,
    JMP_JALR = 4'd8
  } jmp_t;

  function automatic logic jmp_resolve(jmp_t kind, logic eq, logic lt, logic ltu);
    case (kind)
      JMP_BEQ:            return eq;
      JMP_BNE:            return !eq;
      JMP_BLT:            return lt;
      JMP_BGE:            return !lt;
      JMP_BLTU:           return ltu;
      JMP_BGEU:           return !ltu;
      JMP_JAL, JMP_JALR:  return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

  function automatic ctr_t ctr_inc(ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dec(ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pcgen_btb.sv
// rtl/pcgen_btb.sv - direct-mapped branch target buffer with 2-bit counters
module pcgen_btb
  import pcgen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-3:0]  target;
    ctr_t             ctr;
  } btb_entry_t;

  btb_entry_t     mem [BTB_ENTRIES];
  logic [IDX-1:0] rd_idx;
  logic [IDX-1:0] wr_idx;
  btb_entry_t     rd_e;
  btb_entry_t     wr_e;
  logic           rd_hit;
  logic           wr_hit;
  logic           unused_lsbs;

  assign unused_lsbs = ^{pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign rd_idx = pc[IDX+1:2];
  assign rd_e   = mem[rd_idx];
  assign rd_hit = rd_e.valid && (rd_e.tag == pc[XLEN-1:IDX+2]);

  assign pred_taken  = rd_hit && rd_e.ctr[1];
  assign pred_target = pred_taken ? {rd_e.target, 2'b00} : pc_plus4;

  assign wr_idx = upd_pc[IDX+1:2];
  assign wr_e   = mem[wr_idx];
  assign wr_hit = wr_e.valid && (wr_e.tag == upd_pc[XLEN-1:IDX+2]);

  // A taken miss steals the slot outright; not-taken misses never allocate
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        mem[wr_idx].target <= upd_target[XLEN-1:2];
        if (wr_hit) begin
          mem[wr_idx].ctr <= ctr_inc(wr_e.ctr);
        end else begin
          mem[wr_idx].valid <= 1'b1;
          mem[wr_idx].tag   <= upd_pc[XLEN-1:IDX+2];
          mem[wr_idx].ctr   <= WT;
        end
      end else if (wr_hit) begin
        mem[wr_idx].ctr <= ctr_dec(wr_e.ctr);
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC register and next-PC select; BTB built only with PCGEN_BTB_EN
module pc_gen
  import pcgen_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [XLEN-1:0] next_pc;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign pc_plus4 = pc + XLEN'(4);

`ifdef PCGEN_BTB_EN
  pcgen_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rstn        (rstn),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .pred_taken  (pred_taken),
    .pred_target (pred_target)
  );
`else
  logic unused_upd;

  assign unused_upd  = ^{upd_valid, upd_pc, upd_taken, upd_target};
  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
`endif

  // Redirect wins over stall so a flush is never lost behind back-pressure
  always_comb begin
    next_pc = pc_plus4;
    if (redirect_valid) begin
      next_pc = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (stall) begin
      next_pc = pc;
    end else if (pred_taken) begin
      next_pc = pred_target;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen, with or without PCGEN_BTB_EN
module tb_pc_gen;

  localparam int          N   = 16;
  localparam logic [31:0] RPC = 32'h100;
`ifdef PCGEN_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pred_taken;
  logic [31:0] pred_target;

  int tests = 0;
  int fails = 0;

  pc_gen #(
    .XLEN        (32),
    .RESET_PC    (RPC),
    .BTB_ENTRIES (N)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Reference model: BTB as plain arrays indexed by word address modulo depth
  logic [31:0] m_pc;
  bit          m_v   [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 4) % N);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] a);
    return a / (4 * N);
  endfunction

  task automatic m_reset();
    m_pc = RPC;
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
  endtask

  task automatic m_predict(input logic [31:0] a, output bit tk, output logic [31:0] tg);
    int i;
    bit hit;
    i   = m_idx(a);
    hit = BTB_ON && m_v[i] && (m_tag[i] == m_tagof(a));
    tk  = hit && (m_ctr[i] >= 2);
    tg  = tk ? m_tgt[i] : a + 32'd4;
  endtask

  task automatic m_step();
    bit          tk;
    bit          hit;
    int          i;
    logic [31:0] tg;
    logic [31:0] nxt;
    m_predict(m_pc, tk, tg);
    if (redirect_valid)  nxt = redirect_pc & ~32'd3;
    else if (stall)      nxt = m_pc;
    else if (tk)         nxt = tg;
    else                 nxt = m_pc + 32'd4;
    if (BTB_ON && upd_valid) begin
      i   = m_idx(upd_pc);
      hit = m_v[i] && (m_tag[i] == m_tagof(upd_pc));
      if (upd_taken) begin
        m_tgt[i] = upd_target & ~32'd3;
        if (hit) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        end else begin
          m_v[i] = 1'b1; m_tag[i] = m_tagof(upd_pc); m_ctr[i] = 2;
        end
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end
    m_pc = nxt;
  endtask

  typedef struct {
    string       name;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit          tk;
    logic [31:0] tg;
    int          tk_seq [9];
    int          pr_seq [9];
    int          prev;

    vecs[0] = '{"seq0",          1'b0, 1'b0, 32'h0,         32'h104};
    vecs[1] = '{"seq1",          1'b0, 1'b0, 32'h0,         32'h108};
    vecs[2] = '{"stall_hold",    1'b1, 1'b0, 32'h0,         32'h108};
    vecs[3] = '{"redir_over_st", 1'b1, 1'b1, 32'h203,       32'h200};
    vecs[4] = '{"redir_top",     1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC};
    vecs[5] = '{"wrap",          1'b0, 1'b0, 32'h0,         32'h0};
    vecs[6] = '{"stall_zero",    1'b1, 1'b0, 32'h0,         32'h0};
    vecs[7] = '{"redir_align",   1'b0, 1'b1, 32'h1001,      32'h1000};

    do_reset();
    check("reset_pc", pc, RPC);
    check("reset_pc_plus4", pc_plus4, RPC + 32'd4);
    check("reset_pred_taken", 32'(pred_taken), 32'd0);

    for (int k = 0; k < 8; k++) begin
      stall = vecs[k].stall; redirect_valid = vecs[k].rv; redirect_pc = vecs[k].rpc;
      tick();
      check({vecs[k].name, "_pc"}, pc, vecs[k].exp_pc);
      check({vecs[k].name, "_pc_plus4"}, pc_plus4, vecs[k].exp_pc + 32'd4);
      check({vecs[k].name, "_pred"}, 32'(pred_taken), 32'd0);
    end
    idle();

    // Counter training at 0x40 while fetch is held there
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    idle();
    check("train_start_pc", pc, 32'h40);
    check("train_start_pred", 32'(pred_taken), 32'd0);
    tk_seq = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    pr_seq = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    prev = 0;
    stall = 1'b1;
    for (int k = 0; k < 9; k++) begin
      upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = tk_seq[k][0]; upd_target = 32'h80;
      #1;
      check("train_same_cycle_old", 32'(pred_taken), 32'(prev));
      tick();
      prev = BTB_ON ? pr_seq[k] : 0;
      check("train_pred", 32'(pred_taken), 32'(prev));
    end
    idle();
    check("train_target", pred_target, BTB_ON ? 32'h80 : 32'h44);
    tick();
    check("train_follow_pc", pc, BTB_ON ? 32'h80 : 32'h44);
    check("alias_pred", 32'(pred_taken), 32'd0);
    check("alias_target", pred_target, BTB_ON ? 32'h84 : 32'h48);

    // Asynchronous reset mid-cycle clears PC now and BTB for later lookups
    #3 rstn = 1'b0;
    #1;
    check("async_reset_pc", pc, RPC);
    check("async_reset_pred", 32'(pred_taken), 32'd0);
    tick();
    rstn = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    idle();
    check("post_reset_pc", pc, 32'h40);
    check("post_reset_btb_clear", 32'(pred_taken), 32'd0);
    check("post_reset_target", pred_target, 32'h44);

    // Randomized run against the model
    do_reset();
    m_reset();
    for (int c = 0; c < 2000; c++) begin
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FC00 | $urandom_range(0, 1023))
                                                   : $urandom_range(0, 1023);
      upd_valid      = ($urandom_range(0, 1) == 1);
      upd_pc         = $urandom_range(0, 32'h1FF) & ~32'd3;
      upd_taken      = ($urandom_range(0, 2) != 0);
      upd_target     = $urandom_range(0, 32'h1FF);
      m_predict(m_pc, tk, tg);
      check("rand_pc", pc, m_pc);
      check("rand_pc_plus4", pc_plus4, m_pc + 32'd4);
      check("rand_pred_taken", 32'(pred_taken), 32'(tk));
      check("rand_pred_target", pred_target, tg);
      m_step();
      tick();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
